// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode, state, instruction-class and datapath-select encodings shared by the control unit and ALU control.
package ctrl_pkg;
  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010, OP_OR = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100, OP_SHIFT = 4'b0101, OP_LW = 4'b0111, OP_SW = 4'b1000;
  localparam logic [3:0] OP_BEQ = 4'b1001, OP_JAL = 4'b1100, OP_JALR = 4'b1101;
  localparam logic [3:0] OP_LUI = 4'b1110, OP_LBI = 4'b1111;
  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_EXEC_R = 4'd2, ST_EXEC_I = 4'd3;
  localparam logic [3:0] ST_MEM_ADDR = 4'd4, ST_MEM_READ = 4'd5, ST_MEM_WRITE = 4'd6, ST_WB_ALU = 4'd7;
  localparam logic [3:0] ST_WB_MEM = 4'd8, ST_BRANCH = 4'd9, ST_JUMP = 4'd10, ST_TRAP = 4'd11;
  typedef enum logic [3:0] {
    S_FETCH = ST_FETCH, S_DECODE = ST_DECODE, S_EXEC_R = ST_EXEC_R, S_EXEC_I = ST_EXEC_I,
    S_MEM_ADDR = ST_MEM_ADDR, S_MEM_READ = ST_MEM_READ, S_MEM_WRITE = ST_MEM_WRITE,
    S_WB_ALU = ST_WB_ALU, S_WB_MEM = ST_WB_MEM, S_BRANCH = ST_BRANCH, S_JUMP = ST_JUMP, S_TRAP = ST_TRAP
  } state_t;
  typedef enum logic [2:0] {CL_R, CL_I, CL_MEM, CL_BR, CL_JMP, CL_ILL} opclass_t;
  localparam logic [1:0] A_PC = 2'd0, A_RS = 2'd1, A_ZERO = 2'd2;
  localparam logic [1:0] B_RT = 2'd0, B_TWO = 2'd1, B_IMM = 2'd2, B_SHIMM = 2'd3;
  localparam logic [1:0] PCS_ALU = 2'd0, PCS_ALUOUT = 2'd1, PCS_JUMP = 2'd2;
  localparam logic [1:0] M2R_ALUOUT = 2'd0, M2R_MDR = 2'd1, M2R_PC = 2'd2;
endpackage

// File: rtl/ctrl_opclass.sv
// ctrl_opclass: combinational opcode to instruction-class decoder driving the DECODE transition.
module ctrl_opclass
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output opclass_t   opclass
);
  always_comb begin
    opclass = CL_ILL;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHIFT: opclass = CL_R;
      OP_ADDI, OP_LUI, OP_LBI:                 opclass = CL_I;
      OP_LW, OP_SW:                            opclass = CL_MEM;
      OP_BEQ:                                  opclass = CL_BR;
      OP_JAL, OP_JALR:                         opclass = CL_JMP;
      default:                                 opclass = CL_ILL;
    endcase
  end
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multicycle main control unit with memory ready handshake.
// Define CTRL_TRAP_ILLEGAL_EN to trap (sticky) on illegal opcodes instead of treating them as NOPs.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [3:0]         In_Opcode,
  input  logic [1:0]         In_Si,
  input  logic               In_Zero,
  input  logic               In_MemReady,
  output logic               Out_IRWrite,
  output logic               Out_PCWrite,
  output logic               Out_PCWriteCond,
  output logic               Out_MemRead,
  output logic               Out_MemWrite,
  output logic               Out_RegWrite,
  output logic               Out_PerformAddition,
  output logic [1:0]         Out_ALUSrcA,
  output logic [1:0]         Out_ALUSrcB,
  output logic [1:0]         Out_PCSource,
  output logic [1:0]         Out_MemToReg,
  output logic               Out_IorD,
  output logic [3:0]         Out_Opcode,
  output logic [1:0]         Out_Si,
  output logic [STATE_W-1:0] Out_State,
  output logic               Out_Trap
);
  state_t state, nxt;
  opclass_t opclass;
  logic [3:0] op_q;
  logic [1:0] si_q;
  logic zero_unused;
`ifdef CTRL_TRAP_ILLEGAL_EN
  localparam state_t ILL_NEXT = S_TRAP;
`else
  localparam state_t ILL_NEXT = S_FETCH;
`endif
  // The branch PC load is qualified by In_Zero in the datapath, alongside PCWriteCond.
  assign zero_unused = In_Zero;
  ctrl_opclass u_opclass (.opcode(In_Opcode), .opclass(opclass));
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_FETCH;
      op_q  <= '0;
      si_q  <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) begin
        op_q <= In_Opcode;
        si_q <= In_Si;
      end
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:     nxt = In_MemReady ? S_DECODE : S_FETCH;
      S_DECODE:    nxt = opclass == CL_R   ? S_EXEC_R :
                         opclass == CL_I   ? S_EXEC_I :
                         opclass == CL_MEM ? S_MEM_ADDR :
                         opclass == CL_BR  ? S_BRANCH :
                         opclass == CL_JMP ? S_JUMP : ILL_NEXT;
      S_EXEC_R:    nxt = S_WB_ALU;
      S_EXEC_I:    nxt = S_WB_ALU;
      S_MEM_ADDR:  nxt = op_q == OP_LW ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  nxt = In_MemReady ? S_WB_MEM : S_MEM_READ;
      S_MEM_WRITE: nxt = In_MemReady ? S_FETCH : S_MEM_WRITE;
      S_TRAP:      nxt = S_TRAP;
      default:     nxt = S_FETCH;
    endcase
  end
  always_comb begin
    {Out_IRWrite, Out_PCWrite, Out_PCWriteCond, Out_MemRead, Out_MemWrite, Out_RegWrite} = '0;
    Out_PerformAddition = 1'b0;
    Out_IorD = 1'b0;
    Out_ALUSrcA = A_PC;
    Out_ALUSrcB = B_RT;
    Out_PCSource = PCS_ALU;
    Out_MemToReg = M2R_ALUOUT;
    case (state)
      S_FETCH: begin
        Out_MemRead = 1'b1;
        Out_IRWrite = In_MemReady;
        Out_PCWrite = In_MemReady;
        Out_PerformAddition = 1'b1;
        Out_ALUSrcB = B_TWO;
      end
      S_DECODE: begin
        Out_PerformAddition = 1'b1;
        Out_ALUSrcB = B_SHIMM;
      end
      S_EXEC_R: Out_ALUSrcA = A_RS;
      S_EXEC_I: begin
        Out_ALUSrcA = (op_q == OP_LUI || op_q == OP_LBI) ? A_ZERO : A_RS;
        Out_ALUSrcB = B_IMM;
      end
      S_WB_ALU: Out_RegWrite = 1'b1;
      S_MEM_ADDR: begin
        Out_ALUSrcA = A_RS;
        Out_ALUSrcB = B_IMM;
        Out_PerformAddition = 1'b1;
      end
      S_MEM_READ: begin
        Out_MemRead = 1'b1;
        Out_IorD = 1'b1;
      end
      S_WB_MEM: begin
        Out_RegWrite = 1'b1;
        Out_MemToReg = M2R_MDR;
      end
      S_MEM_WRITE: begin
        Out_MemWrite = 1'b1;
        Out_IorD = 1'b1;
      end
      S_BRANCH: begin
        Out_ALUSrcA = A_RS;
        Out_PCWriteCond = 1'b1;
        Out_PCSource = PCS_ALUOUT;
      end
      S_JUMP: begin
        Out_RegWrite = 1'b1;
        Out_MemToReg = M2R_PC;
        Out_PCWrite = 1'b1;
        Out_PCSource = op_q == OP_JALR ? PCS_ALU : PCS_JUMP;
        Out_ALUSrcA = op_q == OP_JALR ? A_RS : A_PC;
        Out_ALUSrcB = op_q == OP_JALR ? B_IMM : B_RT;
        Out_PerformAddition = op_q == OP_JALR;
      end
      default: ;
    endcase
    // Write strobes must drop the moment reset asserts, even while FETCH sees In_MemReady.
    if (!RST_N) {Out_IRWrite, Out_PCWrite, Out_PCWriteCond, Out_MemWrite, Out_RegWrite} = '0;
  end
  assign Out_Opcode = op_q;
  assign Out_Si = si_q;
  assign Out_State = STATE_W'(state);
`ifdef CTRL_TRAP_ILLEGAL_EN
  assign Out_Trap = state == S_TRAP;
`else
  assign Out_Trap = 1'b0;
`endif
endmodule
